// File: rtl/pulse_event_monitor.sv
// Edge-detects the upstream count_pulse level and counts rises while armed.
// Raises a sticky done at the programmed threshold and flags overflow until acknowledged.
module pulse_event_monitor #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_in,
  input  logic [CNT_W-1:0] thresh,
  input  logic             start,
  input  logic             stop,
  input  logic             ack,
  output logic [CNT_W-1:0] event_count,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic             pulse_d_r;
  logic             rise_s;
  logic [CNT_W-1:0] thr_r, thr_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             ovf_r, ovf_s;
  logic             err_r, err_s;
  logic             busy_r, done_r;

  assign rise_s    = pulse_in & ~pulse_d_r;
  assign cnt_inc_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

  // Next-state and next-value logic for the run controller
  always_comb begin
    state_s = state_r;
    thr_s   = thr_r;
    cnt_s   = cnt_r;
    ovf_s   = ovf_r;
    err_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (thresh != {CNT_W{1'b0}}) begin
            thr_s   = thresh;
            cnt_s   = {CNT_W{1'b0}};
            ovf_s   = 1'b0;
            state_s = ARMED;
          end else begin
            err_s   = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ARMED: begin
        // stop outranks a same-cycle rise, which is then dropped
        if (stop) begin
          state_s = IDLE;
        end else if (rise_s) begin
          cnt_s = cnt_inc_s;
          if (cnt_inc_s == thr_r) begin
            state_s = DONE;
          end else begin
            state_s = ARMED;
          end
        end else begin
          state_s = ARMED;
        end
      end
      DONE: begin
        if (ack) begin
          state_s = IDLE;
          ovf_s   = 1'b0;
        end else if (rise_s) begin
          ovf_s   = 1'b1;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers; busy/done follow the next state so they are flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      pulse_d_r <= 1'b0;
      thr_r     <= {CNT_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      ovf_r     <= 1'b0;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      pulse_d_r <= pulse_in;
      thr_r     <= thr_s;
      cnt_r     <= cnt_s;
      ovf_r     <= ovf_s;
      err_r     <= err_s;
      busy_r    <= (state_s == ARMED);
      done_r    <= (state_s == DONE);
    end
  end

  assign event_count = cnt_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign overflow    = ovf_r;
  assign err         = err_r;

endmodule

// File: tb/tb_pulse_event_monitor.sv
// Directed self-checking bench for pulse_event_monitor with hand-computed expectations.
module tb_pulse_event_monitor;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             pulse_in;
  logic [CNT_W-1:0] thresh;
  logic             start;
  logic             stop;
  logic             ack;
  logic [CNT_W-1:0] event_count;
  logic             busy;
  logic             done;
  logic             overflow;
  logic             err;

  int checks;
  int errors;

  pulse_event_monitor #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pulse_in    (pulse_in),
    .thresh      (thresh),
    .start       (start),
    .stop        (stop),
    .ack         (ack),
    .event_count (event_count),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [CNT_W-1:0] cnt, input logic b,
                         input logic d, input logic o, input logic e);
    chk({tag, ".count"}, 32'(event_count), 32'(cnt));
    chk({tag, ".busy"},  32'(busy),        32'(b));
    chk({tag, ".done"},  32'(done),        32'(d));
    chk({tag, ".ovf"},   32'(overflow),    32'(o));
    chk({tag, ".err"},   32'(err),         32'(e));
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    pulse_in = 1'b0;
    thresh   = 8'd0;
    start    = 1'b0;
    stop     = 1'b0;
    ack      = 1'b0;
    #3;
    chk_all("reset", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #9 rst_n = 1'b1;
    tick();

    // Three spaced pulses, threshold 3
    thresh = 8'd3; start = 1'b1; tick(); start = 1'b0;
    chk_all("arm3", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_in = 1'b1; tick(); pulse_in = 1'b0;
    chk_all("p1", 8'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); tick(); tick();
    pulse_in = 1'b1; tick(); pulse_in = 1'b0;
    chk_all("p2", 8'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); tick(); tick();
    pulse_in = 1'b1; tick(); pulse_in = 1'b0;
    chk_all("p3_done", 8'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();

    // Rise while done pending -> overflow, count frozen; then ack
    pulse_in = 1'b1; tick(); pulse_in = 1'b0;
    chk_all("ovf", 8'd3, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    ack = 1'b1; tick(); ack = 1'b0;
    chk_all("ack", 8'd3, 1'b0, 1'b0, 1'b0, 1'b0);

    // Held level counts once, threshold 5
    thresh = 8'd5; start = 1'b1; tick(); start = 1'b0;
    chk_all("arm5", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_in = 1'b1; tick();
    chk("held_first", 32'(event_count), 32'd1);
    tick(); tick(); tick(); tick(); tick();
    chk("held_six", 32'(event_count), 32'd1);
    pulse_in = 1'b0; tick(); tick();
    pulse_in = 1'b1; tick(); pulse_in = 1'b0;
    chk_all("held_second", 8'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    stop = 1'b1; tick(); stop = 1'b0;
    chk_all("stop5", 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);

    // stop beats a same-cycle rise, threshold 4
    thresh = 8'd4; start = 1'b1; tick(); start = 1'b0;
    chk("arm4.count", 32'(event_count), 32'd0);
    pulse_in = 1'b1; tick(); pulse_in = 1'b0; tick();
    pulse_in = 1'b1; tick(); pulse_in = 1'b0; tick();
    chk("arm4.two", 32'(event_count), 32'd2);
    stop = 1'b1; pulse_in = 1'b1; tick(); stop = 1'b0; pulse_in = 1'b0;
    chk_all("stop_rise", 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Zero threshold rejected, err for exactly one cycle
    thresh = 8'd0; start = 1'b1; tick(); start = 1'b0;
    chk_all("zero_thr", 8'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("err_one_cycle", 32'(err), 32'd0);

    // Re-start while armed is ignored and threshold is not resampled
    thresh = 8'd2; start = 1'b1; tick(); start = 1'b0;
    chk_all("arm2", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_in = 1'b1; tick(); pulse_in = 1'b0;
    chk("arm2.one", 32'(event_count), 32'd1);
    thresh = 8'd7; start = 1'b1; tick(); start = 1'b0;
    chk_all("restart_ign", 8'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_in = 1'b1; tick(); pulse_in = 1'b0;
    chk_all("arm2_done", 8'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();

    // ack beats a same-cycle rise: no overflow
    ack = 1'b1; pulse_in = 1'b1; tick(); ack = 1'b0; pulse_in = 1'b0;
    chk_all("ack_rise", 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Threshold 1 completes on the first rise
    thresh = 8'd1; start = 1'b1; tick(); start = 1'b0;
    pulse_in = 1'b1; tick(); pulse_in = 1'b0;
    chk_all("thr1", 8'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    ack = 1'b1; tick(); ack = 1'b0;

    // Async reset mid-run, then pulse already high after release
    thresh = 8'd3; start = 1'b1; tick(); start = 1'b0;
    pulse_in = 1'b1; tick(); pulse_in = 1'b0;
    chk("pre_rst.count", 32'(event_count), 32'd1);
    #2 rst_n = 1'b0; pulse_in = 1'b1;
    #1;
    chk_all("async_rst", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    tick();
    chk_all("post_rst", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk_all("held_arm", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_in = 1'b0; tick();
    pulse_in = 1'b1; tick(); pulse_in = 1'b0;
    chk_all("fresh_rise", 8'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
